tboom_rename_unit_nw: RTL and testbench
=======================================

# tboom_rename_unit_nw

Parametrised N-wide register rename stage. It renames up to RENAME_WIDTH instructions per cycle and owns its map table, bit-vector freelist and branch checkpoints, with no external submodules. It resolves intra-group RAW/WAW dependencies for any width and presents renamed operands through a registered valid/ready output stage. It sits between decode and dispatch/ROB; the commit logic returns stale physical registers to it.

## Interface
- RENAME_WIDTH, 2, instructions per group (W)
- COMMIT_WIDTH, 2, stale registers freed per cycle (C)
- REG_ARCH_ADDR_WIDTH, 5, architectural index width (A)
- REG_PHYS_ADDR_WIDTH, 6, physical index width (P); NUM_PHYS = 2^P must exceed 2^A
- CHECKPOINT_DEPTH, 8, checkpoint slots (D)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  synchronous, active-low reset
- in_valid / in_rd_valid / in_rs1_valid / in_rs2_valid  in  W each  per-slot valid flags
- in_arch_rs1 / in_arch_rs2 / in_arch_rd  in  W*A each  slot i at bits [i*A +: A]
- in_ready  out  1  group accepted when high
- out_valid  out  1  registered group valid
- out_slot_valid  out  W  copy of the accepted in_valid
- out_phys_rs1 / out_phys_rs2 / out_phys_rd / out_phys_stale  out  W*P each  renamed fields
- out_ready  in  1  consumer accepts the output
- commit_valid  in  C  free request per lane
- commit_pdst_old  in  C*P  stale physical register to free
- checkpoint  in  1  snapshot into slot checkpoint_pos
- restore  in  1  restore from slot checkpoint_pos; acts as a flush
- checkpoint_pos  in  $clog2(D)  slot index
- free_count  out  $clog2(NUM_PHYS+1)  registered count of free registers

## Operation
- State: map table of 2^A×P, free bit vector of NUM_PHYS, D map snapshots, D alloc_since masks of NUM_PHYS bits.
- need = number of slots with in_valid & in_rd_valid & in_arch_rd≠0.
- in_ready = !restore & (!out_valid | out_ready) & (free_count ≥ need). Acceptance requires in_ready and any in_valid. A group is renamed entirely or not at all.
- Allocation: the k-th requesting slot, in slot order, gets the k-th lowest-index free register. Non-requesting slots output phys_rd = 0.
- Sources: rs with valid=0 or arch=0 gives 0. Otherwise the result is phys_rd of the highest slot j<i whose rd matches; if none matches, the map-table entry.
- Stale: uses the same bypass rule on in_arch_rd. It is 0 when the slot does not request.
- Map update: written in slot order, so the youngest writer wins on WAW. x0 is never remapped.
- Commit: each valid lane with pdst≠0 sets its free bit. Freeing an already-free register is ignored, and duplicate lanes count once. Freed registers become allocatable the next cycle.
- free_count_next = free_count − allocated + newly freed.
- Checkpoint: slot pos takes a snapshot of the map after this cycle's group, and alloc_since[pos] is cleared. Every other slot's alloc_since ORs in this cycle's allocations.
- Restore: map ← snapshot[pos]; free |= alloc_since[pos]; free_count is recomputed (popcount); out_valid ← 0; no group is accepted. Commits in the same cycle still apply. Restore beats checkpoint.

## Timing
- Latency is 1 cycle: an accepted group appears on out_* with out_valid on the next edge.
- When out_valid & !out_ready, all out_* hold stable.
- Reset values:
  - map[i] = i; free bits set for 2^A..NUM_PHYS−1; free_count = NUM_PHYS−2^A.
  - out_valid = 0, out_slot_valid and all out_phys_* = 0.
  - Snapshots are the identity map; alloc_since = 0.
- Reset mid-operation discards the output and all checkpoints.

## Test plan
All scenarios use W=2, A=5, P=6.
- After reset, free_count = 32. Slot0 rd x1, rs x2,x3; slot1 rd x4, rs1 x1. Next cycle: slot0 rd=32, rs1=2, rs2=3, stale=1; slot1 rd=33, rs1=32, stale=4; free_count=30.
- WAW, both slots rd x5. Result: slot0 rd=32, stale=5; slot1 rd=33, stale=32. A later read of x5 gives 33.
- rd x0 with rd_valid=1. Result: phys_rd=0, no allocation, free_count unchanged.
- Drain until free_count=1, then present a two-rd group: in_ready=0. Commit pdst_old=7: next cycle free_count=2, in_ready=1, and allocation returns 7 first.
- Checkpoint pos 3, rename x1 twice (34, 35), then restore pos 3. Result: x1 maps to the pre-checkpoint value, free_count is back, out_valid=0, and 34/35 are free again.
- Hold out_ready=0 with a valid output: outputs stay stable and in_ready=0. Assert rst_n=0 for one cycle: reset values on the next edge.

Source files
------------

// File: rtl/tboom_rename_unit_nw.sv
// N-wide register rename stage: map table, bit-vector freelist, branch checkpoints
// and a registered valid/ready output stage, with intra-group RAW/WAW bypass.
module tboom_rename_unit_nw #(
    parameter int RENAME_WIDTH        = 2,
    parameter int COMMIT_WIDTH        = 2,
    parameter int REG_ARCH_ADDR_WIDTH = 5,
    parameter int REG_PHYS_ADDR_WIDTH = 6,
    parameter int CHECKPOINT_DEPTH    = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [RENAME_WIDTH-1:0]                         in_valid,
    input  logic [RENAME_WIDTH-1:0]                         in_rd_valid,
    input  logic [RENAME_WIDTH-1:0]                         in_rs1_valid,
    input  logic [RENAME_WIDTH-1:0]                         in_rs2_valid,
    input  logic [RENAME_WIDTH*REG_ARCH_ADDR_WIDTH-1:0]     in_arch_rs1,
    input  logic [RENAME_WIDTH*REG_ARCH_ADDR_WIDTH-1:0]     in_arch_rs2,
    input  logic [RENAME_WIDTH*REG_ARCH_ADDR_WIDTH-1:0]     in_arch_rd,
    output logic                                            in_ready,
    output logic                                            out_valid,
    output logic [RENAME_WIDTH-1:0]                         out_slot_valid,
    output logic [RENAME_WIDTH*REG_PHYS_ADDR_WIDTH-1:0]     out_phys_rs1,
    output logic [RENAME_WIDTH*REG_PHYS_ADDR_WIDTH-1:0]     out_phys_rs2,
    output logic [RENAME_WIDTH*REG_PHYS_ADDR_WIDTH-1:0]     out_phys_rd,
    output logic [RENAME_WIDTH*REG_PHYS_ADDR_WIDTH-1:0]     out_phys_stale,
    input  logic                                            out_ready,
    input  logic [COMMIT_WIDTH-1:0]                         commit_valid,
    input  logic [COMMIT_WIDTH*REG_PHYS_ADDR_WIDTH-1:0]     commit_pdst_old,
    input  logic                                            checkpoint,
    input  logic                                            restore,
    input  logic [$clog2(CHECKPOINT_DEPTH)-1:0]             checkpoint_pos,
    output logic [$clog2((1<<REG_PHYS_ADDR_WIDTH)+1)-1:0]   free_count
);

    localparam int unsigned W        = RENAME_WIDTH;
    localparam int unsigned C        = COMMIT_WIDTH;
    localparam int unsigned A        = REG_ARCH_ADDR_WIDTH;
    localparam int unsigned P        = REG_PHYS_ADDR_WIDTH;
    localparam int unsigned D        = CHECKPOINT_DEPTH;
    localparam int unsigned CPW      = $clog2(CHECKPOINT_DEPTH);
    localparam int unsigned NUM_PHYS = 1 << P;
    localparam int unsigned NUM_ARCH = 1 << A;
    localparam int unsigned FCW      = $clog2(NUM_PHYS + 1);
    localparam logic [NUM_PHYS-1:0] FREE_RESET =
        {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

    logic [P-1:0]          map_q [NUM_ARCH];
    logic [P-1:0]          snap_q [D][NUM_ARCH];
    logic [NUM_PHYS-1:0]   alloc_since_q [D];
    logic [NUM_PHYS-1:0]   free_q;
    logic [FCW-1:0]        free_count_q;

    logic                  out_valid_q;
    logic [W-1:0]          out_slot_valid_q;
    logic [W*P-1:0]        out_rs1_q, out_rs2_q, out_rd_q, out_stale_q;

    logic [W-1:0]          req;
    logic [FCW-1:0]        need;
    logic                  accept;
    logic [P-1:0]          alloc_phys [W];
    logic [NUM_PHYS-1:0]   avail, alloc_mask, commit_mask, new_free, free_n;
    logic [FCW-1:0]        fc_n;
    logic [P-1:0]          map_n [NUM_ARCH];
    logic [W*P-1:0]        rs1_n, rs2_n, rd_n, stale_n;
    logic                  found;
    logic [A-1:0]          rs1_a, rs2_a, rd_a;
    logic [P-1:0]          s1, s2, st;

    function automatic logic [FCW-1:0] popcount(input logic [NUM_PHYS-1:0] v);
        logic [FCW-1:0] n;
        n = '0;
        for (int unsigned k = 0; k < NUM_PHYS; k++) begin
            n = n + FCW'(v[k]);
        end
        return n;
    endfunction

    always_comb begin
        req = '0;
        need = '0;
        for (int unsigned i = 0; i < W; i++) begin
            req[i] = in_valid[i] & in_rd_valid[i] & (in_arch_rd[i*A +: A] != '0);
            need = need + FCW'(req[i]);
        end
    end

    assign in_ready = !restore && (!out_valid_q || out_ready) && (free_count_q >= need);
    assign accept   = in_ready && (|in_valid);

    // k-th requesting slot takes the k-th lowest free index
    always_comb begin
        avail = free_q;
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            alloc_phys[i] = '0;
        end
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i]) begin
                found = 1'b0;
                for (int unsigned p = 0; p < NUM_PHYS; p++) begin
                    if (!found && avail[p]) begin
                        alloc_phys[i] = P'(p);
                        avail[p]      = 1'b0;
                        found         = 1'b1;
                    end
                end
            end
        end
        alloc_mask = accept ? (free_q & ~avail) : '0;
    end

    // Operand renaming with bypass from the youngest older writer in the group
    always_comb begin
        rs1_n   = '0;
        rs2_n   = '0;
        rd_n    = '0;
        stale_n = '0;
        rs1_a   = '0;
        rs2_a   = '0;
        rd_a    = '0;
        s1      = '0;
        s2      = '0;
        st      = '0;
        for (int unsigned i = 0; i < W; i++) begin
            rs1_a = in_arch_rs1[i*A +: A];
            rs2_a = in_arch_rs2[i*A +: A];
            rd_a  = in_arch_rd[i*A +: A];
            s1 = map_q[rs1_a];
            s2 = map_q[rs2_a];
            st = map_q[rd_a];
            for (int unsigned j = 0; j < i; j++) begin
                if (req[j]) begin
                    if (in_arch_rd[j*A +: A] == rs1_a) s1 = alloc_phys[j];
                    if (in_arch_rd[j*A +: A] == rs2_a) s2 = alloc_phys[j];
                    if (in_arch_rd[j*A +: A] == rd_a)  st = alloc_phys[j];
                end
            end
            if (!in_rs1_valid[i] || rs1_a == '0) s1 = '0;
            if (!in_rs2_valid[i] || rs2_a == '0) s2 = '0;
            if (!req[i]) st = '0;
            rs1_n[i*P +: P]   = s1;
            rs2_n[i*P +: P]   = s2;
            rd_n[i*P +: P]    = req[i] ? alloc_phys[i] : '0;
            stale_n[i*P +: P] = st;
        end
    end

    always_comb begin
        for (int unsigned a = 0; a < NUM_ARCH; a++) begin
            map_n[a] = map_q[a];
        end
        for (int unsigned i = 0; i < W; i++) begin
            if (accept && req[i]) begin
                map_n[in_arch_rd[i*A +: A]] = alloc_phys[i];
            end
        end
    end

    // Only registers not already free are counted, so duplicates and stale frees are harmless
    always_comb begin
        commit_mask = '0;
        for (int unsigned c = 0; c < C; c++) begin
            if (commit_valid[c] && commit_pdst_old[c*P +: P] != '0) begin
                commit_mask[commit_pdst_old[c*P +: P]] = 1'b1;
            end
        end
        new_free = commit_mask & ~free_q;
        if (restore) begin
            free_n = free_q | alloc_since_q[checkpoint_pos] | new_free;
            fc_n   = popcount(free_n);
        end else begin
            free_n = (free_q & ~alloc_mask) | new_free;
            fc_n   = free_count_q - (accept ? need : '0) + popcount(new_free);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned a = 0; a < NUM_ARCH; a++) begin
                map_q[a] <= P'(a);
                for (int unsigned d = 0; d < D; d++) begin
                    snap_q[d][a] <= P'(a);
                end
            end
            for (int unsigned d = 0; d < D; d++) begin
                alloc_since_q[d] <= '0;
            end
            free_q       <= FREE_RESET;
            free_count_q <= FCW'(NUM_PHYS - NUM_ARCH);
        end else begin
            free_q       <= free_n;
            free_count_q <= fc_n;
            for (int unsigned a = 0; a < NUM_ARCH; a++) begin
                map_q[a] <= restore ? snap_q[checkpoint_pos][a] : map_n[a];
            end
            if (!restore) begin
                for (int unsigned d = 0; d < D; d++) begin
                    if (checkpoint && checkpoint_pos == CPW'(d)) begin
                        for (int unsigned a = 0; a < NUM_ARCH; a++) begin
                            snap_q[d][a] <= map_n[a];
                        end
                        alloc_since_q[d] <= '0;
                    end else begin
                        alloc_since_q[d] <= alloc_since_q[d] | alloc_mask;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_slot_valid_q <= '0;
            out_rs1_q        <= '0;
            out_rs2_q        <= '0;
            out_rd_q         <= '0;
            out_stale_q      <= '0;
        end else if (restore) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q      <= 1'b1;
            out_slot_valid_q <= in_valid;
            out_rs1_q        <= rs1_n;
            out_rs2_q        <= rs2_n;
            out_rd_q         <= rd_n;
            out_stale_q      <= stale_n;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_slot_valid = out_slot_valid_q;
    assign out_phys_rs1   = out_rs1_q;
    assign out_phys_rs2   = out_rs2_q;
    assign out_phys_rd    = out_rd_q;
    assign out_phys_stale = out_stale_q;
    assign free_count     = free_count_q;

endmodule

// File: tb/tb_tboom_rename_unit_nw.sv
// Directed bench for tboom_rename_unit_nw (W=2, A=5, P=6): vector table plus
// hand-written multi-cycle sequences for freelist exhaustion, hold and reset.
module tb_tboom_rename_unit_nw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid, in_rd_valid, in_rs1_valid, in_rs2_valid;
    logic [9:0]  in_arch_rs1, in_arch_rs2, in_arch_rd;
    logic        in_ready, out_valid;
    logic [1:0]  out_slot_valid;
    logic [11:0] out_phys_rs1, out_phys_rs2, out_phys_rd, out_phys_stale;
    logic        out_ready;
    logic [1:0]  commit_valid;
    logic [11:0] commit_pdst_old;
    logic        checkpoint, restore;
    logic [2:0]  checkpoint_pos;
    logic [6:0]  free_count;

    int checks = 0;
    int errors = 0;

    tboom_rename_unit_nw #(
        .RENAME_WIDTH(2), .COMMIT_WIDTH(2), .REG_ARCH_ADDR_WIDTH(5),
        .REG_PHYS_ADDR_WIDTH(6), .CHECKPOINT_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_rd_valid(in_rd_valid),
        .in_rs1_valid(in_rs1_valid), .in_rs2_valid(in_rs2_valid),
        .in_arch_rs1(in_arch_rs1), .in_arch_rs2(in_arch_rs2), .in_arch_rd(in_arch_rd),
        .in_ready(in_ready), .out_valid(out_valid), .out_slot_valid(out_slot_valid),
        .out_phys_rs1(out_phys_rs1), .out_phys_rs2(out_phys_rs2),
        .out_phys_rd(out_phys_rd), .out_phys_stale(out_phys_stale),
        .out_ready(out_ready), .commit_valid(commit_valid), .commit_pdst_old(commit_pdst_old),
        .checkpoint(checkpoint), .restore(restore), .checkpoint_pos(checkpoint_pos),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  vld, rdv, r1v, r2v;
        logic [9:0]  rs1, rs2, rd;
        logic        ck, rs;
        logic [2:0]  pos;
        logic        e_rdy, e_ov;
        logic [1:0]  e_sv;
        logic [11:0] e_rs1, e_rs2, e_rd, e_st;
        logic [6:0]  e_fc;
    } vec_t;

    vec_t vt [8];

    function automatic logic [9:0] a2(input int s1, input int s0);
        return {s1[4:0], s0[4:0]};
    endfunction

    function automatic logic [11:0] p2(input int s1, input int s0);
        return {s1[5:0], s0[5:0]};
    endfunction

    function automatic vec_t mkv(
        input string nm, input logic [1:0] vld, input logic [1:0] rdv,
        input logic [1:0] r1v, input logic [1:0] r2v,
        input logic [9:0] rs1, input logic [9:0] rs2, input logic [9:0] rd,
        input logic ck, input logic rs, input logic [2:0] pos,
        input logic e_rdy, input logic e_ov, input logic [1:0] e_sv,
        input logic [11:0] e_rs1, input logic [11:0] e_rs2,
        input logic [11:0] e_rd, input logic [11:0] e_st, input logic [6:0] e_fc);
        vec_t v;
        v.name = nm; v.vld = vld; v.rdv = rdv; v.r1v = r1v; v.r2v = r2v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ck = ck; v.rs = rs; v.pos = pos;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_sv = e_sv;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rd = e_rd; v.e_st = e_st; v.e_fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_rd_valid = '0; in_rs1_valid = '0; in_rs2_valid = '0;
        in_arch_rs1 = '0; in_arch_rs2 = '0; in_arch_rd = '0;
        out_ready = 1'b1; commit_valid = '0; commit_pdst_old = '0;
        checkpoint = 1'b0; restore = 1'b0; checkpoint_pos = '0;
    endtask

    task automatic group(input logic [1:0] vld, input logic [1:0] rdv, input logic [1:0] r1v,
                         input logic [1:0] r2v, input logic [9:0] rs1, input logic [9:0] rs2,
                         input logic [9:0] rd);
        in_valid = vld; in_rd_valid = rdv; in_rs1_valid = r1v; in_rs2_valid = r2v;
        in_arch_rs1 = rs1; in_arch_rs2 = rs2; in_arch_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nf;
        int fc;

        vt[0] = mkv("idle", 2'b00, 2'b00, 2'b00, 2'b00, a2(0,0), a2(0,0), a2(0,0), 0, 0, 3'd0,
                    1, 0, 2'b00, p2(0,0), p2(0,0), p2(0,0), p2(0,0), 7'd32);
        vt[1] = mkv("basic", 2'b11, 2'b11, 2'b11, 2'b01, a2(1,2), a2(0,3), a2(4,1), 0, 0, 3'd0,
                    1, 1, 2'b11, p2(32,2), p2(0,3), p2(33,32), p2(4,1), 7'd30);
        vt[2] = mkv("waw", 2'b11, 2'b11, 2'b00, 2'b00, a2(0,0), a2(0,0), a2(5,5), 0, 0, 3'd0,
                    1, 1, 2'b11, p2(0,0), p2(0,0), p2(35,34), p2(34,5), 7'd28);
        vt[3] = mkv("rd_x0", 2'b01, 2'b01, 2'b01, 2'b01, a2(0,5), a2(0,1), a2(0,0), 0, 0, 3'd0,
                    1, 1, 2'b01, p2(0,35), p2(0,32), p2(0,0), p2(0,0), 7'd28);
        vt[4] = mkv("ckpt3", 2'b00, 2'b00, 2'b00, 2'b00, a2(0,0), a2(0,0), a2(0,0), 1, 0, 3'd3,
                    1, 0, 2'b00, p2(0,0), p2(0,0), p2(0,0), p2(0,0), 7'd28);
        vt[5] = mkv("x1_twice", 2'b11, 2'b11, 2'b10, 2'b00, a2(1,0), a2(0,0), a2(1,1), 0, 0, 3'd0,
                    1, 1, 2'b11, p2(36,0), p2(0,0), p2(37,36), p2(36,32), 7'd26);
        vt[6] = mkv("restore3", 2'b11, 2'b11, 2'b00, 2'b00, a2(0,0), a2(0,0), a2(3,3), 0, 1, 3'd3,
                    0, 0, 2'b00, p2(0,0), p2(0,0), p2(0,0), p2(0,0), 7'd28);
        vt[7] = mkv("post_restore", 2'b01, 2'b01, 2'b01, 2'b01, a2(0,1), a2(0,5), a2(0,2), 0, 0, 3'd0,
                    1, 1, 2'b01, p2(0,32), p2(0,35), p2(0,36), p2(0,2), 7'd27);

        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_free_count", free_count, 32);
        chk("reset_rd", out_phys_rd, 0);
        #1 chk("reset_in_ready", in_ready, 1);

        for (int k = 0; k < 8; k++) begin
            group(vt[k].vld, vt[k].rdv, vt[k].r1v, vt[k].r2v, vt[k].rs1, vt[k].rs2, vt[k].rd);
            checkpoint = vt[k].ck; restore = vt[k].rs; checkpoint_pos = vt[k].pos;
            #1 chk({vt[k].name, "_in_ready"}, in_ready, vt[k].e_rdy);
            tick();
            chk({vt[k].name, "_out_valid"}, out_valid, vt[k].e_ov);
            chk({vt[k].name, "_free_count"}, free_count, vt[k].e_fc);
            if (vt[k].e_ov) begin
                chk({vt[k].name, "_slot_valid"}, out_slot_valid, vt[k].e_sv);
                chk({vt[k].name, "_rs1"}, out_phys_rs1, vt[k].e_rs1);
                chk({vt[k].name, "_rs2"}, out_phys_rs2, vt[k].e_rs2);
                chk({vt[k].name, "_rd"}, out_phys_rd, vt[k].e_rd);
                chk({vt[k].name, "_stale"}, out_phys_stale, vt[k].e_st);
            end
        end
        idle_inputs();

        // Drain the freelist two at a time; 37 and 38..63 are free here
        nf = 37;
        fc = 27;
        for (int g = 0; g < 13; g++) begin
            group(2'b11, 2'b11, 2'b00, 2'b00, a2(0,0), a2(0,0), a2(11,10));
            #1 chk("drain_in_ready", in_ready, 1);
            tick();
            chk("drain_rd", out_phys_rd, p2(nf + 1, nf));
            nf += 2;
            fc -= 2;
            chk("drain_free_count", free_count, fc);
        end

        // One free register left: a two-rd group must stall; free 7 and an already-free 63
        commit_valid = 2'b11;
        commit_pdst_old = p2(63, 7);
        #1 chk("starved_in_ready", in_ready, 0);
        tick();
        chk("starved_out_valid", out_valid, 0);
        chk("commit_free_count", free_count, 2);
        commit_valid = '0;
        #1 chk("refill_in_ready", in_ready, 1);
        tick();
        chk("refill_rd", out_phys_rd, p2(63, 7));
        chk("refill_stale", out_phys_stale, p2(62, 61));
        chk("refill_free_count", free_count, 0);

        // Consumer stalls: output holds; duplicate commit lanes count once
        out_ready = 1'b0;
        group(2'b11, 2'b00, 2'b00, 2'b00, a2(0,0), a2(0,0), a2(0,0));
        commit_valid = 2'b11;
        commit_pdst_old = p2(40, 40);
        #1 chk("hold_in_ready", in_ready, 0);
        tick();
        chk("hold_out_valid", out_valid, 1);
        chk("hold_rd", out_phys_rd, p2(63, 7));
        chk("hold_stale", out_phys_stale, p2(62, 61));
        chk("dup_commit_free_count", free_count, 1);
        commit_valid = 2'b01;
        commit_pdst_old = p2(41, 0);
        tick();
        chk("hold2_rd", out_phys_rd, p2(63, 7));
        chk("hold2_out_valid", out_valid, 1);
        chk("zero_commit_free_count", free_count, 1);

        // Reset mid-operation
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_free_count", free_count, 32);
        chk("rst2_slot_valid", out_slot_valid, 0);
        chk("rst2_rs1", out_phys_rs1, 0);
        chk("rst2_rd", out_phys_rd, 0);
        chk("rst2_stale", out_phys_stale, 0);

        // Checkpoints were discarded: restoring slot 3 yields the identity map
        out_ready = 1'b1;
        restore = 1'b1;
        checkpoint_pos = 3'd3;
        #1 chk("rst2_restore_in_ready", in_ready, 0);
        tick();
        chk("rst2_restore_free_count", free_count, 32);
        restore = 1'b0;
        group(2'b01, 2'b01, 2'b01, 2'b00, a2(0,1), a2(0,0), a2(0,1));
        tick();
        chk("rst2_rs1", out_phys_rs1, p2(0, 1));
        chk("rst2_rd_alloc", out_phys_rd, p2(0, 32));
        chk("rst2_stale_x1", out_phys_stale, p2(0, 1));
        chk("rst2_fc_after", free_count, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
